// File: rtl/zbus_master.sv
// zbus_master -- Z80 bus-cycle initiator.
//
// Turns single-transaction requests from an internal master into Z80 pin
// activity: memory read/write, I/O read/write and opcode fetch with refresh.
// T-states advance only on clk edges where ce is high. Strobes are active-low
// and registered.
//
// Build option: define ZBUS_REFRESH_EN to drive the refresh half of opcode
// fetch (rfsh_n/mreq_n low, a = {i_reg, r_out}) and to increment r_out.
// Without it, T3/T4 of a fetch are idle bus states and r_out stays at RST_R.
//
// Ports:
//   clk, rst                 fabric clock, synchronous active-high reset
//   ce                       T-state enable
//   req, cmd, addr, wdata    transaction request (cmd 0..4 valid)
//   i_reg                    I register, high byte of refresh address
//   wait_n, din              Z80 WAIT and read data bus
//   busy, done, rdata        status, completion pulse, captured read data
//   a, dout, dout_oe         address bus, write data, data drive enable
//   m1_n .. rfsh_n           Z80 strobes
//   r_out                    R register
module zbus_master #(
   parameter logic [7:0] RST_R = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        req,
   input  logic [2:0]  cmd,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   input  logic [7:0]  i_reg,
   input  logic        wait_n,
   input  logic [7:0]  din,
   output logic        busy,
   output logic        done,
   output logic [7:0]  rdata,
   output logic [15:0] a,
   output logic [7:0]  dout,
   output logic        dout_oe,
   output logic        m1_n,
   output logic        mreq_n,
   output logic        iorq_n,
   output logic        rd_n,
   output logic        wr_n,
   output logic        rfsh_n,
   output logic [7:0]  r_out
);

   typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, T4} state_t;

   localparam logic [2:0] CMD_MEMRD = 3'd0;
   localparam logic [2:0] CMD_MEMWR = 3'd1;
   localparam logic [2:0] CMD_IORD  = 3'd2;
   localparam logic [2:0] CMD_IOWR  = 3'd3;
   localparam logic [2:0] CMD_OPF   = 3'd4;

`ifdef ZBUS_REFRESH_EN
   localparam bit REFRESH_EN = 1'b1;
`else
   localparam bit REFRESH_EN = 1'b0;
`endif

   state_t      state, next_state;
   logic [2:0]  cmd_q, n_cmd, eff_cmd;
   logic        last_exit;
   logic        n_m1_n, n_mreq_n, n_iorq_n, n_rd_n, n_wr_n, n_rfsh_n, n_oe;
   logic [15:0] n_a;
   logic [7:0]  n_dout, n_rdata, n_r;

   assign busy = (state != IDLE);

   // Next-state logic plus the registered-output values that belong to the
   // state being entered, so pins change on the same ce edge as the state.
   always_comb begin
      next_state = state;
      last_exit  = 1'b0;
      n_cmd      = cmd_q;
      eff_cmd    = cmd_q;
      n_a        = a;
      n_dout     = dout;
      n_rdata    = rdata;
      n_r        = r_out;
      n_m1_n     = 1'b1;
      n_mreq_n   = 1'b1;
      n_iorq_n   = 1'b1;
      n_rd_n     = 1'b1;
      n_wr_n     = 1'b1;
      n_rfsh_n   = 1'b1;
      n_oe       = 1'b0;

      case (state)
         IDLE: begin
            if (req && (cmd <= CMD_OPF)) begin
               next_state = T1;
               n_cmd      = cmd;
               eff_cmd    = cmd;
               n_a        = addr;
               n_dout     = wdata;
            end
         end
         T1: next_state = T2;
         // I/O always gets one TW; memory and fetch only when WAIT is low
         T2: begin
            if ((cmd_q == CMD_IORD) || (cmd_q == CMD_IOWR) || !wait_n)
               next_state = TW;
            else
               next_state = T3;
         end
         TW: next_state = wait_n ? T3 : TW;
         T3: begin
            if (cmd_q == CMD_OPF) begin
               next_state = T4;
            end else begin
               next_state = IDLE;
               last_exit  = 1'b1;
               if ((cmd_q == CMD_MEMRD) || (cmd_q == CMD_IORD))
                  n_rdata = din;
            end
         end
         T4: begin
            next_state = IDLE;
            last_exit  = 1'b1;
            if (REFRESH_EN)
               n_r = {r_out[7], r_out[6:0] + 7'd1};
         end
         default: next_state = IDLE;
      endcase

      // Opcode is taken on the way into T3, and the refresh address is put
      // out with the R value from before this fetch's increment.
      if ((cmd_q == CMD_OPF) && ((state == T2) || (state == TW)) && (next_state == T3)) begin
         n_rdata = din;
         if (REFRESH_EN)
            n_a = {i_reg, r_out};
      end

      // Strobe decode for the state being entered
      case (next_state)
         T1: begin
            case (eff_cmd)
               CMD_MEMRD: begin n_mreq_n = 1'b0; n_rd_n = 1'b0; end
               CMD_MEMWR: begin n_mreq_n = 1'b0; n_oe = 1'b1; end
               CMD_OPF:   begin n_m1_n = 1'b0; n_mreq_n = 1'b0; n_rd_n = 1'b0; end
               default: ;
            endcase
         end
         T2, TW, T3: begin
            case (eff_cmd)
               CMD_MEMRD: begin n_mreq_n = 1'b0; n_rd_n = 1'b0; end
               CMD_MEMWR: begin n_mreq_n = 1'b0; n_wr_n = 1'b0; n_oe = 1'b1; end
               CMD_IORD:  begin n_iorq_n = 1'b0; n_rd_n = 1'b0; end
               CMD_IOWR:  begin n_iorq_n = 1'b0; n_wr_n = 1'b0; n_oe = 1'b1; end
               CMD_OPF: begin
                  if (next_state != T3) begin
                     n_m1_n   = 1'b0;
                     n_mreq_n = 1'b0;
                     n_rd_n   = 1'b0;
                  end else if (REFRESH_EN) begin
                     n_mreq_n = 1'b0;
                     n_rfsh_n = 1'b0;
                  end
               end
               default: ;
            endcase
         end
         T4: begin
            if (REFRESH_EN) begin
               n_mreq_n = 1'b0;
               n_rfsh_n = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // State and output registers; everything except done holds when ce is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cmd_q   <= CMD_MEMRD;
         done    <= 1'b0;
         rdata   <= 8'h00;
         a       <= 16'h0000;
         dout    <= 8'h00;
         dout_oe <= 1'b0;
         m1_n    <= 1'b1;
         mreq_n  <= 1'b1;
         iorq_n  <= 1'b1;
         rd_n    <= 1'b1;
         wr_n    <= 1'b1;
         rfsh_n  <= 1'b1;
         r_out   <= RST_R;
      end else begin
         done <= 1'b0;
         if (ce) begin
            state   <= next_state;
            cmd_q   <= n_cmd;
            done    <= last_exit;
            rdata   <= n_rdata;
            a       <= n_a;
            dout    <= n_dout;
            dout_oe <= n_oe;
            m1_n    <= n_m1_n;
            mreq_n  <= n_mreq_n;
            iorq_n  <= n_iorq_n;
            rd_n    <= n_rd_n;
            wr_n    <= n_wr_n;
            rfsh_n  <= n_rfsh_n;
            r_out   <= n_r;
         end
      end
   end

endmodule

// File: tb/tb_zbus_master.sv
// tb_zbus_master -- directed self-checking bench for zbus_master.
// Instantiated with RST_R = 8'h7F so the first opcode fetch wraps R to 8'h00
// when ZBUS_REFRESH_EN is defined.
module tb_zbus_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce = 1'b1;
   logic        req = 1'b0;
   logic [2:0]  cmd = 3'd0;
   logic [15:0] addr = 16'h0000;
   logic [7:0]  wdata = 8'h00;
   logic [7:0]  i_reg = 8'h00;
   logic        wait_n = 1'b1;
   logic [7:0]  din = 8'h00;
   logic        busy, done, dout_oe;
   logic [7:0]  rdata, dout, r_out;
   logic [15:0] a;
   logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;

   int tests_run = 0;
   int tests_failed = 0;

   zbus_master #(.RST_R(8'h7F)) dut (
      .clk(clk), .rst(rst), .ce(ce), .req(req), .cmd(cmd), .addr(addr),
      .wdata(wdata), .i_reg(i_reg), .wait_n(wait_n), .din(din),
      .busy(busy), .done(done), .rdata(rdata), .a(a), .dout(dout),
      .dout_oe(dout_oe), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
      .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .r_out(r_out)
   );

   // Free-running fabric clock
   always #5 clk = ~clk;

   // Advance one clk; observation happens on the falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      tests_run++;
      if ({m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} !== 6'h3F) begin
         tests_failed++;
         $display("[TB] FAIL reset_strobes: got %b expected 111111", {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n});
      end
      tests_run++;
      if ({busy, done, dout_oe} !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, dout_oe});
      end
      tests_run++;
      if ({a, dout, rdata} !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_buses: got %h expected 00000000", {a, dout, rdata});
      end
      tests_run++;
      if (r_out !== 8'h7F) begin
         tests_failed++;
         $display("[TB] FAIL reset_r: got %h expected 7f", r_out);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_memrd();
      int lowcnt = 0;
      bit seen = 0;
      req = 1'b1; cmd = 3'd0; addr = 16'h8000; din = 8'hA5; wait_n = 1'b1; ce = 1'b1;
      tick();
      req = 1'b0;
      tests_run++;
      if (a !== 16'h8000) begin
         tests_failed++;
         $display("[TB] FAIL memrd_addr: got %h expected 8000", a);
      end
      for (int i = 0; i < 10 && !seen; i++) begin
         if (!mreq_n && !rd_n) lowcnt++;
         if (done) seen = 1;
         else tick();
      end
      tests_run++;
      if (seen !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL memrd_done_timeout: got %0d expected 1", seen);
      end
      tests_run++;
      if (lowcnt !== 3) begin
         tests_failed++;
         $display("[TB] FAIL memrd_strobe_len: got %0d expected 3", lowcnt);
      end
      tests_run++;
      if ({rdata, busy, mreq_n, rd_n} !== {8'hA5, 3'b011}) begin
         tests_failed++;
         $display("[TB] FAIL memrd_end: got %h/%b expected a5/011", rdata, {busy, mreq_n, rd_n});
      end
      tick();
      tests_run++;
      if (done !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL memrd_done_pulse: got %b expected 0", done);
      end
   endtask

   task automatic test_memwr_wait();
      int edges = 0;
      int wrlow = 0;
      int oecnt = 0;
      req = 1'b1; cmd = 3'd1; addr = 16'h4000; wdata = 8'h3C; wait_n = 1'b1; ce = 1'b1;
      tick();
      req = 1'b0;
      tests_run++;
      if ({mreq_n, wr_n, dout_oe, dout} !== {3'b011, 8'h3C}) begin
         tests_failed++;
         $display("[TB] FAIL memwr_t1: got %b/%h expected 011/3c", {mreq_n, wr_n, dout_oe}, dout);
      end
      // Edge 1 leaves T1; edges 2 and 3 see WAIT low in T2 and the first TW
      while (!done && edges < 12) begin
         if (!wr_n) wrlow++;
         if (dout_oe) oecnt++;
         wait_n = ((edges + 1 == 2) || (edges + 1 == 3)) ? 1'b0 : 1'b1;
         tick();
         edges++;
      end
      wait_n = 1'b1;
      tests_run++;
      if (edges !== 5) begin
         tests_failed++;
         $display("[TB] FAIL memwr_edges: got %0d expected 5", edges);
      end
      tests_run++;
      if (wrlow !== 4) begin
         tests_failed++;
         $display("[TB] FAIL memwr_wr_len: got %0d expected 4", wrlow);
      end
      tests_run++;
      if (oecnt !== 5) begin
         tests_failed++;
         $display("[TB] FAIL memwr_oe_len: got %0d expected 5", oecnt);
      end
      tests_run++;
      if ({dout_oe, wr_n, mreq_n, a} !== {3'b011, 16'h4000}) begin
         tests_failed++;
         $display("[TB] FAIL memwr_end: got %b/%h expected 011/4000", {dout_oe, wr_n, mreq_n}, a);
      end
      tick();
   endtask

   task automatic test_iowr_slow_ce();
      int clks = 0;
      int iorq_low = 0;
      int wr_low = 0;
      int m1_low = 0;
      req = 1'b1; cmd = 3'd3; addr = 16'h00FE; wdata = 8'h07; wait_n = 1'b1; ce = 1'b1;
      tick();
      req = 1'b0;
      tests_run++;
      if ({iorq_n, wr_n, dout_oe, a} !== {3'b110, 16'h00FE}) begin
         tests_failed++;
         $display("[TB] FAIL iowr_t1: got %b/%h expected 110/00fe", {iorq_n, wr_n, dout_oe}, a);
      end
      while (!done && clks < 40) begin
         if (!iorq_n) iorq_low++;
         if (!wr_n) wr_low++;
         if (!m1_n) m1_low++;
         ce = ((clks + 1) % 4 == 0);
         tick();
         clks++;
      end
      tests_run++;
      if (clks !== 16) begin
         tests_failed++;
         $display("[TB] FAIL iowr_clks_to_done: got %0d expected 16", clks);
      end
      tests_run++;
      if (iorq_low !== 12 || wr_low !== 12) begin
         tests_failed++;
         $display("[TB] FAIL iowr_strobe_len: got %0d/%0d expected 12/12", iorq_low, wr_low);
      end
      tests_run++;
      if (m1_low !== 0) begin
         tests_failed++;
         $display("[TB] FAIL iowr_m1: got %0d expected 0", m1_low);
      end
      ce = 1'b0;
      tick();
      tests_run++;
      if ({done, busy, iorq_n} !== 3'b001) begin
         tests_failed++;
         $display("[TB] FAIL iowr_done_ce_low: got %b expected 001", {done, busy, iorq_n});
      end
      ce = 1'b1;
      tick();
   endtask

   task automatic test_opfetch();
      req = 1'b1; cmd = 3'd4; addr = 16'h1234; i_reg = 8'h3F; din = 8'h5A; wait_n = 1'b1; ce = 1'b1;
      tick();
      req = 1'b0;
      tests_run++;
      if ({m1_n, mreq_n, rd_n, rfsh_n, a} !== {4'b0001, 16'h1234}) begin
         tests_failed++;
         $display("[TB] FAIL opf_t1: got %b/%h expected 0001/1234", {m1_n, mreq_n, rd_n, rfsh_n}, a);
      end
      tick();
      tick();
      din = 8'hFF;
      tests_run++;
      if (rdata !== 8'h5A) begin
         tests_failed++;
         $display("[TB] FAIL opf_rdata_t3: got %h expected 5a", rdata);
      end
      for (int t = 3; t <= 4; t++) begin
         tests_run++;
`ifdef ZBUS_REFRESH_EN
         if ({m1_n, mreq_n, rd_n, rfsh_n, a} !== {4'b1010, 16'h3F7F}) begin
            tests_failed++;
            $display("[TB] FAIL opf_refresh_t%0d: got %b/%h expected 1010/3f7f", t, {m1_n, mreq_n, rd_n, rfsh_n}, a);
         end
`else
         if ({m1_n, mreq_n, rd_n, rfsh_n, a} !== {4'b1111, 16'h1234}) begin
            tests_failed++;
            $display("[TB] FAIL opf_norefresh_t%0d: got %b/%h expected 1111/1234", t, {m1_n, mreq_n, rd_n, rfsh_n}, a);
         end
`endif
         tick();
      end
      tests_run++;
      if ({done, busy, rdata} !== {2'b10, 8'h5A}) begin
         tests_failed++;
         $display("[TB] FAIL opf_end: got %b/%h expected 10/5a", {done, busy}, rdata);
      end
      tests_run++;
`ifdef ZBUS_REFRESH_EN
      if (r_out !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL opf_r_wrap: got %h expected 00", r_out);
      end
`else
      if (r_out !== 8'h7F) begin
         tests_failed++;
         $display("[TB] FAIL opf_r_hold: got %h expected 7f", r_out);
      end
`endif
      tick();
   endtask

   task automatic test_back_to_back();
      int n = 0;
      req = 1'b1; cmd = 3'd0; addr = 16'h0100; din = 8'h11; wait_n = 1'b1; ce = 1'b1;
      tick();
      while (!done && n < 10) begin tick(); n++; end
      tests_run++;
      if ({done, busy, rdata} !== {2'b10, 8'h11}) begin
         tests_failed++;
         $display("[TB] FAIL b2b_first: got %b/%h expected 10/11", {done, busy}, rdata);
      end
      addr = 16'h0200; din = 8'h22;
      tick();
      req = 1'b0;
      tests_run++;
      if ({done, busy, mreq_n, a} !== {3'b010, 16'h0200}) begin
         tests_failed++;
         $display("[TB] FAIL b2b_second_accept: got %b/%h expected 010/0200", {done, busy, mreq_n}, a);
      end
      n = 0;
      while (!done && n < 10) begin tick(); n++; end
      tests_run++;
      if ({done, rdata} !== {1'b1, 8'h22}) begin
         tests_failed++;
         $display("[TB] FAIL b2b_second: got %b/%h expected 1/22", done, rdata);
      end
      tick();
   endtask

   task automatic test_rst_mid_cycle();
      int dones = 0;
      req = 1'b1; cmd = 3'd2; addr = 16'h0055; wait_n = 1'b0; ce = 1'b1;
      tick();
      req = 1'b0;
      tick();
      tick();
      tick();
      tests_run++;
      if ({busy, iorq_n, rd_n} !== 3'b100) begin
         tests_failed++;
         $display("[TB] FAIL iord_tw: got %b expected 100", {busy, iorq_n, rd_n});
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_n = 1'b1;
      tests_run++;
      if ({m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, busy, done} !== 8'b11111100) begin
         tests_failed++;
         $display("[TB] FAIL rst_mid: got %b expected 11111100", {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, busy, done});
      end
      tests_run++;
      if ({a, rdata, r_out} !== {16'h0000, 8'h00, 8'h7F}) begin
         tests_failed++;
         $display("[TB] FAIL rst_mid_regs: got %h expected 0000007f", {a, rdata, r_out});
      end
      for (int i = 0; i < 6; i++) begin
         if (done) dones++;
         tick();
      end
      tests_run++;
      if (dones !== 0) begin
         tests_failed++;
         $display("[TB] FAIL rst_mid_no_done: got %0d expected 0", dones);
      end
   endtask

   task automatic test_bad_cmd();
      int active = 0;
      req = 1'b1; ce = 1'b1;
      for (int c = 5; c <= 7; c++) begin
         cmd = 3'(c);
         for (int i = 0; i < 3; i++) begin
            tick();
            if (busy || done || ({m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} != 6'h3F)) active++;
         end
      end
      req = 1'b0;
      tests_run++;
      if (active !== 0) begin
         tests_failed++;
         $display("[TB] FAIL bad_cmd_activity: got %0d expected 0", active);
      end
   endtask

   initial begin
      test_reset();
      test_memrd();
      test_memwr_wait();
      test_iowr_slow_ce();
      test_opfetch();
      test_back_to_back();
      test_rst_mid_cycle();
      test_bad_cmd();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/zbus_master.md
# zbus_master

Z80 bus-cycle initiator. It turns single-transaction requests from an internal master (DMA, debug or test engine) into cycle-accurate Z80 pin activity: memory read, memory write, I/O read, I/O write and opcode fetch with refresh. T-states advance on a CPU clock-enable, and `wait_n` inserts wait states. The outputs are active-low Z80 strobes, so they feed the existing Z80 signal decoder and memory/port arbiters unchanged.

## Interface
- `RST_R`, default 8'h00: R register value loaded on reset.
- `clk` in 1: fabric clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ce` in 1: T-state enable; the FSM advances only on `clk` edges where `ce`=1.
- `req` in 1: transaction request (level).
- `cmd` in 3: 0 memrd, 1 memwr, 2 iord, 3 iowr, 4 opfetch; 5–7 are never accepted.
- `addr` in 16: transaction address.
- `wdata` in 8: write data.
- `i_reg` in 8: I register, used as the high byte of the refresh address.
- `wait_n` in 1: Z80 WAIT, active low.
- `din` in 8: bus read data.
- `busy` out 1: high while a cycle is in progress (state ≠ IDLE).
- `done` out 1: one-`clk` pulse at cycle completion.
- `rdata` out 8: captured read data; holds until the next read completes.
- `a` out 16: address bus.
- `dout` out 8: write data.
- `dout_oe` out 1: data-bus drive enable.
- `m1_n`, `mreq_n`, `iorq_n`, `rd_n`, `wr_n`, `rfsh_n` out 1 each: Z80 strobes.
- `r_out` out 8: current R register.

## Operation
- States: IDLE, T1, T2, TW, T3, T4. All outputs are registered and change only on `ce` edges, except `done`.
- Accept occurs on the edge with `req`=1, `ce`=1, state=IDLE and `cmd`≤4.
  - `cmd`, `addr` and `wdata` are latched.
  - State goes to T1; `a` ← `addr`.
- memrd:
  - T1: `mreq_n`=`rd_n`=0.
  - T2 exit: `wait_n`=0 → TW, else T3. TW repeats while `wait_n`=0.
  - T3 exit: `rdata` ← `din`; all strobes high; → IDLE.
- memwr:
  - T1: `mreq_n`=0, `dout`=`wdata`, `dout_oe`=1.
  - T2–T3: `wr_n`=0. Same wait rule as memrd.
  - T3 exit: strobes high, `dout_oe`=0.
- iord/iowr:
  - T1: address only.
  - T2: `iorq_n`=0, plus `rd_n`=0 or `wr_n`=0 with `dout_oe`=1.
  - One TW is always inserted after T2. Further TW while `wait_n`=0 at TW exit.
  - T3 exit: read captures `din`; strobes high.
- opfetch:
  - T1–T2: `m1_n`=`mreq_n`=`rd_n`=0. Same wait rule as memrd.
  - T2/last-TW exit: `rdata` ← `din`.
  - T3–T4: `m1_n`=`rd_n`=1, `rfsh_n`=0, `mreq_n`=0, `a`={`i_reg`,`r_out`}.
  - T4 exit: strobes high; `r_out[6:0]` increments mod 128; `r_out[7]` is preserved.
- Completion: `done`=1 for exactly the one `clk` after the final state exit (state=IDLE), independent of `ce`.
- Back-to-back: `req` still high on the next `ce` edge in IDLE starts a new cycle. `done` and that accept may coincide.
- `cmd` 5–7 with `req`=1: stays IDLE, no strobes, no `done`.

## Timing
- Reset values: state IDLE; all strobes 1; `a`=0, `dout`=0, `dout_oe`=0, `busy`=0, `done`=0, `rdata`=0, `r_out`=`RST_R`.
- `rst` mid-cycle: next edge forces reset values. No `done`; the cycle is abandoned.
- Minimum cycle length in `ce` edges (accept to IDLE): memrd/memwr 3, io 4, opfetch 4.
- Each wait state adds 1 to these counts.
- `wait_n` is sampled only on `ce` edges in T2 (memory, opfetch) or TW.
- `ce`=1 every `clk` is legal. With `ce`=0, the FSM and all outputs hold.

## Configuration
- `ZBUS_REFRESH_EN` defined: opfetch T3–T4 drive the refresh cycle described above, and `r_out` increments.
- `ZBUS_REFRESH_EN` undefined: T3–T4 still occur, but `rfsh_n` and `mreq_n` stay 1, `a` holds the fetch address, and `r_out` stays at `RST_R`.

## Test plan
- memrd to `addr`=16'h8000, `din`=8'hA5, `wait_n`=1, `ce`=1: `mreq_n`/`rd_n` low 3 clk, `rdata`=8'hA5, `done` pulse, `busy` low.
- memwr 16'h4000 ← 8'h3C with `wait_n` low for 2 `ce` edges in T2: `wr_n` low through T2, 2×TW and T3; `dout_oe`=1 throughout; 5 `ce` edges total.
- iowr port 16'h00FE ← 8'h07 with `ce` every 4th clk: `iorq_n` low from T2, exactly one TW, `m1_n` stays 1, 16 clk to `done`.
- opfetch with `i_reg`=8'h3F and `r_out`=8'h7F (refresh enabled): `rdata` latched at T2 exit; T3–T4 `a`=16'h3F7F with `rfsh_n`=0; afterwards `r_out`=8'h00.
- `rst` asserted during iord TW: next clk all strobes 1, `busy`=0, no `done`. `cmd`=6 with `req`=1 → no activity.
